// File: rtl/surfturf_cmd_scheduler.sv
// Per-frame arbiter that grants the single SURF command slot to runcmd, trig or fw and registers a typed
// 32-bit command word. Define SURFTURF_SCHED_STARVE_EN to build the firmware anti-starvation promotion.
`ifndef RACKBUS_RUNCMD_BITS
`define RACKBUS_RUNCMD_BITS 2
`endif
`ifndef RACKBUS_TRIG_BITS
`define RACKBUS_TRIG_BITS 15
`endif

module surfturf_cmd_scheduler #(
    parameter int FRAME_LEN     = 8,
    parameter int FW_STARVE_MAX = 4
) (
    input  logic                            sysclk_i,
    input  logic                            rst_n_i,
    input  logic                            sync_i,
    input  logic                            fw_enable_i,
    input  logic [`RACKBUS_RUNCMD_BITS-1:0] runcmd_tdata,
    input  logic                            runcmd_tvalid,
    output logic                            runcmd_tready,
    input  logic [`RACKBUS_TRIG_BITS-1:0]   trig_tdata,
    input  logic                            trig_tvalid,
    output logic                            trig_tready,
    input  logic [7:0]                      fw_tdata,
    input  logic                            fw_tvalid,
    output logic                            fw_tready,
    output logic [31:0]                     cmd_o,
    output logic                            cmd_valid_o,
    output logic                            frame_start_o,
    output logic                            fw_starved_o
);
    // Encoding doubles as the command-word type field.
    typedef enum logic [1:0] {
        SRC_IDLE = 2'b00,
        SRC_RUN  = 2'b01,
        SRC_TRIG = 2'b10,
        SRC_FW   = 2'b11
    } src_e;

    localparam logic [7:0] FCNT_LAST = 8'(FRAME_LEN - 1);

    logic [7:0]  fcnt_reg;
    logic [31:0] cmd_reg;
    logic        cmd_valid_reg;
    logic        decision;
    logic        fw_cand;
    logic        promote;
    src_e        grant_sel;
    logic [31:0] cmd_next;

    // A realign pulse landing on the decision cycle suppresses that decision.
    assign decision = (fcnt_reg == FCNT_LAST) && !sync_i;
    assign fw_cand  = fw_tvalid && fw_enable_i;

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fcnt_reg <= '0;
        end else if (sync_i || (fcnt_reg == FCNT_LAST)) begin
            fcnt_reg <= '0;
        end else begin
            fcnt_reg <= fcnt_reg + 8'd1;
        end
    end

`ifdef SURFTURF_SCHED_STARVE_EN
    localparam logic [3:0] SCNT_MAX = 4'(FW_STARVE_MAX);

    logic [3:0] scnt_reg;

    assign promote      = (scnt_reg == SCNT_MAX);
    assign fw_starved_o = promote;

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scnt_reg <= '0;
        end else if (decision) begin
            if (!fw_cand || (grant_sel == SRC_FW)) begin
                scnt_reg <= '0;
            end else if (scnt_reg != SCNT_MAX) begin
                scnt_reg <= scnt_reg + 4'd1;
            end
        end
    end
`else
    assign promote      = 1'b0;
    assign fw_starved_o = 1'b0;
`endif

    always_comb begin
        grant_sel = SRC_IDLE;
        cmd_next  = '0;
        if (decision) begin
            if (promote && fw_cand) begin
                grant_sel = SRC_FW;
            end else if (runcmd_tvalid) begin
                grant_sel = SRC_RUN;
            end else if (trig_tvalid) begin
                grant_sel = SRC_TRIG;
            end else if (fw_cand) begin
                grant_sel = SRC_FW;
            end
        end
        case (grant_sel)
            SRC_RUN:  cmd_next[29:0] = 30'(runcmd_tdata);
            SRC_TRIG: cmd_next[29:0] = 30'(trig_tdata);
            SRC_FW:   cmd_next[29:0] = 30'(fw_tdata);
            default:  cmd_next[29:0] = '0;
        endcase
        cmd_next[31:30] = grant_sel;
    end

    assign runcmd_tready = (grant_sel == SRC_RUN);
    assign trig_tready   = (grant_sel == SRC_TRIG);
    assign fw_tready     = (grant_sel == SRC_FW);

    // The word is held for the whole frame; only a decision cycle refreshes it.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_reg       <= '0;
            cmd_valid_reg <= 1'b0;
        end else begin
            cmd_valid_reg <= decision;
            if (decision) begin
                cmd_reg <= cmd_next;
            end
        end
    end

    assign cmd_o         = cmd_reg;
    assign cmd_valid_o   = cmd_valid_reg;
    assign frame_start_o = (fcnt_reg == 8'd0);

endmodule

// File: doc/surfturf_cmd_scheduler.md
# surfturf_cmd_scheduler

Sysclk-domain arbiter that shares the single per-frame SURF command slot between the runcmd, trigger and firmware-update AXI4-Stream sources produced by the TURFIO SURF register block. A free-running frame counter defines one decision cycle per frame. At that cycle the scheduler grants exactly one source by fixed priority, with an optional firmware anti-starvation guard. It registers the winning payload into a typed 32-bit command word for the rackbus serializer.

## Interface
Parameters:
- FRAME_LEN, 8: sysclk cycles per command frame; legal range 2..256.
- FW_STARVE_MAX, 4: consecutive denied frames before firmware is promoted; legal range 1..15.

Ports:
- sysclk_i  in  1  system clock; the only clock in the block.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- sync_i  in  1  synchronous frame realign pulse.
- fw_enable_i  in  1  firmware source is eligible for grants when high.
- runcmd_tdata/tvalid/tready  in/in/out  `RACKBUS_RUNCMD_BITS`/1/1  run command stream.
- trig_tdata/tvalid/tready  in/in/out  `RACKBUS_TRIG_BITS`/1/1  trigger stream.
- fw_tdata/tvalid/tready  in/in/out  8/1/1  firmware byte stream.
- cmd_o  out  32  current command word, held for the whole frame.
- cmd_valid_o  out  1  one-cycle pulse when cmd_o updates.
- frame_start_o  out  1  high while the frame counter is 0.
- fw_starved_o  out  1  high while the firmware starvation promotion is active.

## Operation
- Frame counter fcnt runs 0..FRAME_LEN-1 and wraps to 0. The decision cycle is fcnt == FRAME_LEN-1.
- Priority at the decision cycle:
  - Without starvation promotion: runcmd > trig > fw.
  - With promotion: fw > runcmd > trig.
- The fw source is a candidate only when fw_tvalid && fw_enable_i.
- Exactly one tready is high, and only in the decision cycle, driven combinationally to the winner. Every tready is 0 in all other cycles.
- A transfer occurs when tvalid && tready. Non-winners are not consumed and stay pending.
- Command word format:
  - cmd_o[31:30]: 00 idle, 01 runcmd, 10 trig, 11 fw.
  - cmd_o[29:0]: winning tdata zero-extended.
  - With no candidate the word is 32'h0, and cmd_valid_o still pulses.
- Starvation counter scnt (4 bits, saturating at FW_STARVE_MAX):
  - Increments at a decision cycle where fw is a candidate but not granted.
  - Clears when fw is granted, or at a decision cycle where fw is not a candidate.
  - Promotion and fw_starved_o are active when scnt == FW_STARVE_MAX.
- sync_i:
  - Forces fcnt to 0 on the next edge and clears any pending decision; no tready is issued in the sync cycle.
  - cmd_o holds its last value; cmd_valid_o does not pulse for the truncated frame.
  - sync_i held high keeps fcnt at 0.
- Runtime changes:
  - Deasserting fw_enable_i stops fw grants at the next decision cycle and clears scnt there.
  - The fw byte already in cmd_o is unaffected.

## Timing
- Reset values (async, rst_n_i low):
  - Outputs: cmd_o = 0, cmd_valid_o = 0, every tready = 0, fw_starved_o = 0, frame_start_o = 1.
  - Internal: fcnt = 0, scnt = 0.
- After reset release, the first decision cycle is FRAME_LEN-1 cycles later.
- Latency: grant in cycle N gives cmd_o and cmd_valid_o updated in cycle N+1, at fcnt == 0.
- A source asserting tvalid just after a decision cycle waits up to FRAME_LEN cycles. Under contention it waits FRAME_LEN × queue depth.
- Reset asserted mid-frame aborts the frame immediately; no partial word is emitted.
- sync_i and a decision cycle coinciding: sync wins, with no grant and no cmd_valid_o.

## Configuration
- SURFTURF_SCHED_STARVE_EN defined:
  - scnt, the promotion logic and fw_starved_o are present.
  - fw is guaranteed at least one grant every FW_STARVE_MAX+1 frames while eligible.
- Not defined:
  - Strict priority runcmd > trig > fw; scnt is absent.
  - fw_starved_o is tied to 0.
  - FW_STARVE_MAX is ignored.

## Test plan
- Reset, then idle sources with FRAME_LEN=8:
  - cmd_valid_o pulses at cycles 8, 16, 24 after release, with cmd_o = 32'h0.
  - tready is never asserted.
- runcmd=2'b10 and trig=15'h1234 both valid before a decision cycle:
  - runcmd_tready pulses, then cmd_o = 32'h4000_0002.
  - Next frame: trig_tready pulses, then cmd_o = 32'h8000_1234.
- fw byte 8'hA5 valid with fw_enable_i=0 for 3 frames:
  - No fw_tready; idle words are emitted.
  - Raising fw_enable_i gives cmd_o = 32'hC000_00A5 at the next frame.
- With the macro defined, FW_STARVE_MAX=4, trig continuously valid, fw valid and enabled:
  - 4 trig frames, with fw_starved_o high after the 4th.
  - 5th frame grants fw; fw_starved_o drops the cycle after.
- Same stimulus without the macro: fw is never granted across 20 frames, and fw_starved_o stays 0.
- sync_i pulsed at fcnt=3:
  - fcnt returns to 0 with no cmd_valid_o.
  - Next decision cycle comes 7 cycles later.
  - rst_n_i dropped mid-frame clears all outputs asynchronously.
